write_buffer: RTL and testbench
===============================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of posted-write entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single system clock, all state changes on rising edge.
REQ-003 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_req  input  1  cache posts a write this cycle.
REQ-005 SHALL have port wr_addr  input  32  posted write address (word aligned).
REQ-006 SHALL have port wr_data  input  32  posted write data.
REQ-007 SHALL have port wb_stall  output  1  buffer cannot accept wr_req this cycle.
REQ-008 SHALL have port wb_empty  output  1  no pending entries and bus idle.
REQ-009 SHALL have port rd_addr  input  32  cache read-miss address for forwarding lookup.
REQ-010 SHALL have port rd_hit  output  1  rd_addr matches a pending entry.
REQ-011 SHALL have port rd_data  output  32  data of youngest matching entry.
REQ-012 SHALL have port BUS_req  output  1  bus request to bus controller (DMA line).
REQ-013 SHALL have port grant  input  1  bus grant from bus controller.
REQ-014 SHALL have port BUS_addr  inout  32  shared address bus, driven only in WAIT, else high-Z.
REQ-015 SHALL have port BUS_data  inout  32  shared data bus, driven only in WAIT, else high-Z.
REQ-016 SHALL have port BUS_RW  inout  1  1 = write, driven only in WAIT, else high-Z.
REQ-017 SHALL have port BUS_ready  input  1  slave completion strobe.

Function
REQ-018 SHALL store entries in FIFO order; head = oldest; count range 0..DEPTH.
REQ-019 SHALL push {wr_addr, wr_data} on rising edge when wr_req=1 and count<DEPTH.
REQ-020 SHALL drive wb_stall = wr_req & (count==DEPTH), combinational; a same-cycle pop SHALL NOT unblock a push.
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT, GAP.
REQ-022 IDLE: BUS_req=0; goes to REQ next cycle when count>0.
REQ-023 REQ: BUS_req=1; goes to WAIT on cycle where grant=1.
REQ-024 WAIT: BUS_req=1, drives head addr/data, BUS_RW=1; on BUS_ready=1 pops head and goes to GAP.
REQ-025 WAIT with grant=0 and BUS_ready=0: SHALL release bus, keep head, return to REQ.
REQ-026 GAP: BUS_req=0 for exactly one cycle (arbitration fairness), then IDLE.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-028 wb_empty SHALL be 1 only when count==0 and state is IDLE.
REQ-029 Minimum bus latency: push at edge N -> BUS_req=1 from cycle N+2.

Reset
REQ-030 clr=1 at a rising edge SHALL clear count and pointers, set state IDLE, regardless of state.
REQ-031 After reset: BUS_req=0, wb_stall=0 (when wr_req=0), wb_empty=1, rd_hit=0, rd_data=0, bus outputs high-Z.
REQ-032 clr in WAIT SHALL discard the in-flight write and release the bus on the next edge; no pop is recorded.
REQ-033 wr_req during clr cycle SHALL be ignored.

Configuration
REQ-034 Macro WB_FORWARD_EN defined: rd_hit/rd_data combinationally compare rd_addr against all valid entries, youngest match wins, entry in WAIT included.
REQ-035 Macro WB_FORWARD_EN undefined: no comparators built; rd_hit=0 and rd_data=0 constant; cache must wait for wb_empty before a read miss.

Verification
REQ-036 Reset then single post addr 0x10 data 0xab21123, grant=1 immediate, BUS_ready 2 cycles later -> one bus write 0x10/0xab21123, BUS_RW=1, GAP cycle, wb_empty=1.
REQ-037 DEPTH=4, five consecutive posts, grant=0 -> wb_stall=1 on fifth; grant released -> four writes in push order, each separated by one BUS_req=0 cycle.
REQ-038 Posts to 0x8 (0xab21128) then 0x8 (0xab21129), rd_addr=0x8 -> with WB_FORWARD_EN rd_hit=1, rd_data=0xab21129; without, rd_hit=0.
REQ-039 In WAIT drop grant before BUS_ready -> bus lines high-Z next cycle, count unchanged, state REQ, same head rewritten on re-grant.
REQ-040 Assert clr while in WAIT with 3 entries -> next cycle count=0, BUS_req=0, wb_empty=1, late BUS_ready ignored.
REQ-041 Full buffer, pop and wr_req same cycle -> push rejected (wb_stall=1), count becomes DEPTH-1; pointer wrap verified over 3*DEPTH writes.

Source files
------------

// File: rtl/write_buffer.sv
// Posted-write FIFO draining to a shared tristate bus via an IDLE/REQ/WAIT/GAP request FSM.
// Define WB_FORWARD_EN to build read-miss forwarding from pending entries.
module write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       wr_req,
    input  logic [31:0]                wr_addr,
    input  logic [31:0]                wr_data,
    output logic                       wb_stall,
    output logic                       wb_empty,
    input  logic [31:0]                rd_addr,
    output logic                       rd_hit,
    output logic [31:0]                rd_data,
    output logic                       BUS_req,
    input  logic                       grant,
    inout  wire  [31:0]                BUS_addr,
    inout  wire  [31:0]                BUS_data,
    inout  wire                        BUS_RW,
    input  logic                       BUS_ready,
    output logic [1:0]                 dbg_state_o,
    output logic [$clog2(DEPTH+1)-1:0] dbg_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    state_t        state_q;
    logic          bus_req_q;
    logic          full;
    logic          push;
    logic          pop;
    logic          bus_drive;

    // Full is judged on the registered count, so a pop in the same cycle never frees a slot.
    assign full     = (count_q == FULL);
    assign push     = wr_req & ~full;
    assign pop      = (state_q == WAIT) & BUS_ready;
    assign wb_stall = wr_req & full;
    assign wb_empty = (count_q == '0) & (state_q == IDLE);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            addr_q[wr_ptr_q] <= wr_addr;
            data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Bus handshake: BUS_req is held while a write is pending; the head is on the bus only in
    // WAIT (grant seen), and a BUS_ready strobe in WAIT completes it. Losing grant before
    // BUS_ready abandons the attempt and the same head is retried.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q   <= REQ;
                        bus_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (grant) state_q <= WAIT;
                end
                WAIT: begin
                    if (BUS_ready) begin
                        state_q   <= GAP;
                        bus_req_q <= 1'b0;
                    end else if (!grant) begin
                        state_q   <= REQ;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUS_req   = bus_req_q;
    assign bus_drive = (state_q == WAIT);
    assign BUS_addr  = bus_drive ? addr_q[rd_ptr_q] : 32'bz;
    assign BUS_data  = bus_drive ? data_q[rd_ptr_q] : 32'bz;
    assign BUS_RW    = bus_drive ? 1'b1 : 1'bz;

    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[rd_ptr_q + PW'(i)] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = data_q[rd_ptr_q + PW'(i)];
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_hit    = 1'b0;
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: hand-computed vectors, a bus-write scoreboard and one summary line.
module tb_write_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          clr       = 1'b1;
    logic          wr_req    = 1'b0;
    logic [31:0]   wr_addr   = '0;
    logic [31:0]   wr_data   = '0;
    logic [31:0]   rd_addr   = '0;
    logic          grant     = 1'b0;
    logic          bus_ready = 1'b0;
    logic          wb_stall;
    logic          wb_empty;
    logic          rd_hit;
    logic [31:0]   rd_data;
    logic          bus_req;
    wire  [31:0]   bus_addr;
    wire  [31:0]   bus_data;
    wire           bus_rw;
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    logic [63:0] exp_q[$];

    write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_stall(wb_stall), .wb_empty(wb_empty), .rd_addr(rd_addr), .rd_hit(rd_hit),
        .rd_data(rd_data), .BUS_req(bus_req), .grant(grant), .BUS_addr(bus_addr),
        .BUS_data(bus_data), .BUS_RW(bus_rw), .BUS_ready(bus_ready),
        .dbg_state_o(dbg_state), .dbg_count_o(dbg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post_ok(input logic [31:0] a, input logic [31:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        exp_q.push_back({a, d});
        cyc(1);
        wr_req  = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int k;
        k = 0;
        while (dbg_state !== s && k < budget) begin
            cyc(1);
            k++;
        end
        check(tag, dbg_state, s);
    endtask

    task automatic drain_one();
        wait_state(S_WAIT, 8, "reach_wait");
        bus_ready = 1'b1;
        cyc(1);
        bus_ready = 1'b0;
        check("gap_state", dbg_state, S_GAP);
        check("gap_bus_req", bus_req, 1'b0);
    endtask

    // Scoreboard: every completed bus write must match the oldest expected posted write.
    always @(negedge clk) begin : bus_monitor
        logic [63:0] e;
        if (!clr && dbg_state == S_WAIT && bus_ready) begin
            if (exp_q.size() == 0) begin
                check("bus_unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bus_addr", bus_addr, e[63:32]);
                check("bus_data", bus_data, e[31:0]);
                check("bus_rw", {31'b0, bus_rw}, 32'd1);
                n_writes++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a write request on the last reset cycle that must be ignored.
        cyc(1);
        wr_req  = 1'b1;
        wr_addr = 32'h44;
        wr_data = 32'h99;
        cyc(1);
        clr    = 1'b0;
        wr_req = 1'b0;
        #1;
        check("rst_count", dbg_count, 0);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_stall", wb_stall, 1'b0);
        check("rst_empty", wb_empty, 1'b1);
        check("rst_rd_hit", rd_hit, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);

        // Single post, immediate grant, ready two cycles after grant.
        grant = 1'b1;
        post_ok(32'h10, 32'h0ab21123);
        check("t1_count", dbg_count, 1);
        check("t1_bus_req_n1", bus_req, 1'b0);
        check("t1_empty_n1", wb_empty, 1'b0);
        cyc(1);
        check("t1_state_req", dbg_state, S_REQ);
        check("t1_bus_req_n2", bus_req, 1'b1);
        cyc(1);
        check("t1_state_wait", dbg_state, S_WAIT);
        cyc(1);
        bus_ready = 1'b1;
        cyc(1);
        bus_ready = 1'b0;
        check("t1_state_gap", dbg_state, S_GAP);
        check("t1_gap_bus_req", bus_req, 1'b0);
        check("t1_gap_empty", wb_empty, 1'b0);
        cyc(1);
        check("t1_idle_empty", wb_empty, 1'b1);
        check("t1_writes", n_writes, 1);

        // Five posts with no grant: the fifth stalls.
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_req  = 1'b1;
            wr_addr = 32'h100 + 32'(4 * i);
            wr_data = 32'hd000 + 32'(i);
            #1;
            check("t2_stall", wb_stall, (i == 4) ? 1'b1 : 1'b0);
            if (i < 4) exp_q.push_back({wr_addr, wr_data});
            cyc(1);
        end
        wr_req = 1'b0;
        check("t2_count_full", dbg_count, 4);
        check("t2_state_req", dbg_state, S_REQ);
        check("t2_bus_req", bus_req, 1'b1);
        grant = 1'b1;
        cyc(1);
        // Full buffer: pop and push in the same cycle, push must be rejected.
        bus_ready = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 32'h200;
        wr_data   = 32'hdead;
        #1;
        check("t2_stall_on_pop", wb_stall, 1'b1);
        cyc(1);
        wr_req    = 1'b0;
        bus_ready = 1'b0;
        check("t2_count_after_pop", dbg_count, 3);
        check("t2_gap_state", dbg_state, S_GAP);
        repeat (3) drain_one();
        wait_state(S_IDLE, 4, "t2_idle");
        check("t2_empty", wb_empty, 1'b1);
        check("t2_writes", n_writes, 5);

        // Forwarding lookup with two posts to the same address.
        grant = 1'b0;
        post_ok(32'h8, 32'h0ab21128);
        post_ok(32'h8, 32'h0ab21129);
        post_ok(32'hc, 32'h55);
        check("t3_count", dbg_count, 3);
        rd_addr = 32'h8;
        #1;
        check("t3_hit_8", rd_hit, FWD);
        check("t3_data_8", rd_data, FWD ? 32'h0ab21129 : 32'h0);
        rd_addr = 32'hc;
        #1;
        check("t3_hit_c", rd_hit, FWD);
        check("t3_data_c", rd_data, FWD ? 32'h55 : 32'h0);
        rd_addr = 32'h20;
        #1;
        check("t3_miss", rd_hit, 1'b0);
        check("t3_miss_data", rd_data, 32'h0);

        // Grant dropped in WAIT: bus released, head kept and retried.
        grant = 1'b1;
        cyc(1);
        check("t4_wait", dbg_state, S_WAIT);
        check("t4_bus_addr", bus_addr, 32'h8);
        check("t4_bus_data", bus_data, 32'h0ab21128);
        check("t4_bus_rw", bus_rw, 1'b1);
        grant = 1'b0;
        cyc(1);
        check("t4_back_req", dbg_state, S_REQ);
        check("t4_bus_req", bus_req, 1'b1);
        check("t4_count", dbg_count, 3);
        grant = 1'b1;
        cyc(1);
        check("t4_rewait", dbg_state, S_WAIT);
        check("t4_re_addr", bus_addr, 32'h8);
        check("t4_re_data", bus_data, 32'h0ab21128);
        rd_addr = 32'h8;
        #1;
        check("t4_fwd_in_wait", rd_data, FWD ? 32'h0ab21129 : 32'h0);
        bus_ready = 1'b1;
        cyc(1);
        bus_ready = 1'b0;
        grant     = 1'b0;
        check("t4_count_after", dbg_count, 2);
        check("t4_fwd_after_pop", rd_hit, FWD);

        // clr while in WAIT with three entries; a late BUS_ready is ignored.
        post_ok(32'h30, 32'h77);
        wait_state(S_REQ, 4, "t5_req");
        check("t5_count", dbg_count, 3);
        grant = 1'b1;
        cyc(1);
        check("t5_wait", dbg_state, S_WAIT);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        exp_q.delete();
        check("t5_count_clr", dbg_count, 0);
        check("t5_bus_req_clr", bus_req, 1'b0);
        check("t5_empty_clr", wb_empty, 1'b1);
        check("t5_state_clr", dbg_state, S_IDLE);
        check("t5_rd_hit_clr", rd_hit, 1'b0);
        bus_ready = 1'b1;
        cyc(1);
        bus_ready = 1'b0;
        check("t5_late_ready_state", dbg_state, S_IDLE);
        check("t5_late_ready_count", dbg_count, 0);
        grant = 1'b0;

        // Simultaneous push and pop with room: count unchanged.
        post_ok(32'h500, 32'h11);
        post_ok(32'h504, 32'h22);
        wait_state(S_REQ, 4, "t6_req");
        grant = 1'b1;
        cyc(1);
        wr_req    = 1'b1;
        wr_addr   = 32'h508;
        wr_data   = 32'h33;
        bus_ready = 1'b1;
        exp_q.push_back({32'h508, 32'h33});
        #1;
        check("t6_no_stall", wb_stall, 1'b0);
        cyc(1);
        wr_req    = 1'b0;
        bus_ready = 1'b0;
        check("t6_count_same", dbg_count, 2);
        check("t6_gap", dbg_state, S_GAP);
        repeat (2) drain_one();
        check("t6_count_zero", dbg_count, 0);

        // Pointer wrap: offset by one entry, then three full batches.
        post_ok(32'h600, 32'h600a);
        drain_one();
        for (int b = 0; b < 3; b++) begin
            grant = 1'b0;
            for (int k = 0; k < 4; k++)
                post_ok(32'h700 + 32'(16 * b + 4 * k), 32'hc000_0000 + 32'(16 * b + k));
            check("t7_count_full", dbg_count, 4);
            rd_addr = 32'h700 + 32'(16 * b + 8);
            #1;
            check("t7_fwd_wrap", rd_data, FWD ? 32'hc000_0000 + 32'(16 * b + 2) : 32'h0);
            grant = 1'b1;
            repeat (4) drain_one();
            check("t7_count_zero", dbg_count, 0);
        end

        wait_state(S_IDLE, 4, "final_idle");
        check("final_empty", wb_empty, 1'b1);
        check("final_writes", n_writes, 22);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
